// File: rtl/ps2_tx_pkg.sv
// Shared PS/2 host-transmitter definitions: FSM encoding, default timings
// and the frame parity helper.
package ps2_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_WAIT_REL
    } state_t;

    localparam int unsigned DEF_INHIBIT_CYCLES = 12_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_500_000;
    localparam int unsigned CNT_W              = 21;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2c synchroniser, FILTER_LEN-deep glitch filter and falling-edge detector.
// Shared with the ps2_rx receiver.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    output logic ps2c_filt_o,
    output logic fall_tick_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] shift_q, shift_d;
    logic                  filt_q, filt_d;
    logic                  fall_q;

    always_comb begin
        shift_d = {sync_q[1], shift_q[FILTER_LEN-1:1]};
        filt_d  = filt_q;
        if (shift_d == '1)
            filt_d = 1'b1;
        else if (shift_d == '0)
            filt_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            shift_q <= '1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], ps2c_i};
            shift_q <= shift_d;
            filt_q  <= filt_d;
            fall_q  <= filt_q & ~filt_d;
        end
    end

    assign ps2c_filt_o = filt_q;
    assign fall_tick_o = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device
// clock falling edges, ACK check and inter-edge watchdog.
module ps2_tx
    import ps2_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    // Inhibit never shorter than the 100 us protocol minimum.
    localparam int unsigned MIN_INHIBIT = CLK_FREQ_HZ / 10_000;
    localparam int unsigned INHIBIT_EFF = (INHIBIT_CYCLES > MIN_INHIBIT) ? INHIBIT_CYCLES : MIN_INHIBIT;
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_EFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [9:0]       frame_q;
    logic [3:0]       bits_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ps2c_low_q, ps2d_low_q;
    logic             idle_q, done_q, err_q;
    logic [1:0]       ps2d_sync_q;
    logic             ps2c_filt, fall_tick;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk        (clk),
        .reset      (reset),
        .ps2c_i     (ps2c),
        .ps2c_filt_o(ps2c_filt),
        .fall_tick_o(fall_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            frame_q     <= '1;
            bits_q      <= '0;
            cnt_q       <= '0;
            ps2c_low_q  <= 1'b0;
            ps2d_low_q  <= 1'b0;
            idle_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ps2d_sync_q <= '1;
        end else begin
            ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_ps2) begin
                        frame_q    <= {1'b1, odd_parity(din), din};
                        bits_q     <= '0;
                        cnt_q      <= '0;
                        ps2c_low_q <= 1'b1;
                        idle_q     <= 1'b0;
                        state_q    <= ST_RTS;
                    end
                end
                ST_RTS: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        cnt_q      <= '0;
                        ps2c_low_q <= 1'b0;
                        ps2d_low_q <= 1'b1;
                        state_q    <= ST_START;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    // Device-clocked states; a fall_tick beats a coincident timeout.
                    if (fall_tick) begin
                        cnt_q <= '0;
                        case (state_q)
                            ST_START: begin
                                ps2d_low_q <= ~frame_q[0];
                                frame_q    <= {1'b1, frame_q[9:1]};
                                bits_q     <= 4'd9;
                                state_q    <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (bits_q != 4'd0) begin
                                    ps2d_low_q <= ~frame_q[0];
                                    frame_q    <= {1'b1, frame_q[9:1]};
                                    bits_q     <= bits_q - 4'd1;
                                end else begin
                                    ps2d_low_q <= 1'b0;
                                    state_q    <= ST_ACK;
                                end
                            end
                            ST_ACK: begin
                                if (!ps2d_sync_q[1]) begin
                                    state_q <= ST_WAIT_REL;
                                end else begin
                                    err_q   <= 1'b1;
                                    idle_q  <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end else if (state_q == ST_WAIT_REL && ps2c_filt && ps2d_sync_q[1]) begin
                        done_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        ps2c_low_q <= 1'b0;
                        ps2d_low_q <= 1'b0;
                        err_q      <= 1'b1;
                        idle_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ps2c         = ps2c_low_q ? 1'b0 : 1'bz;
    assign ps2d         = ps2d_low_q ? 1'b0 : 1'bz;
    assign tx_idle      = idle_q;
    assign tx_done_tick = done_q;
    assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a behavioural PS/2 device on the open-drain pair.
module tb_ps2_tx;

    localparam int INHIBIT = 300;
    localparam int TIMEOUT = 2000;
    localparam int HP      = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       tx_idle, tx_done_tick, tx_err;
    wire        ps2c, ps2d;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_tx #(
        .CLK_FREQ_HZ   (1_000_000),
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT),
        .FILTER_LEN    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) done_cnt++;
        if (tx_err === 1'b1) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        wr_ps2 = 1'b1;
        din    = b;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (ps2c !== 1'b1 && n < 4 * INHIBIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_idle !== 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Device samples ps2d just before each falling edge, so a bit changed
    // while ps2c is high would be captured wrongly.
    task automatic device(input bit ack, input int glitch_edge, output logic [10:0] cap);
        cap = '0;
        cyc(2 * HP);
        for (int e = 1; e <= 12; e++) begin
            if (e <= 11) cap[e-1] = ps2d;
            dev_c_low = 1'b1;
            cyc(HP);
            if (e == 11 && ack) dev_d_low = 1'b1;
            dev_c_low = 1'b0;
            if (e == glitch_edge) begin
                cyc(15);
                dev_c_low = 1'b1;
                cyc(3);
                dev_c_low = 1'b0;
                cyc(HP - 18);
            end else begin
                cyc(HP);
            end
        end
        dev_d_low = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(4);
        checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL rst_idle got=%b exp=1", tx_idle); end
        checks++; if (tx_done_tick !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", tx_done_tick); end
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", tx_err); end
        checks++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin failures++; $display("FAIL rst_lines got=%b%b exp=11", ps2c, ps2d); end
        reset = 1'b0;
        cyc(20);
    endtask

    task automatic test_f4();
        int d0, e0, n;
        logic [10:0] cap;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        checks++; if (ps2c !== 1'b0) begin failures++; $display("FAIL f4_latency ps2c got=%b exp=0", ps2c); end
        checks++; if (tx_idle !== 1'b0) begin failures++; $display("FAIL f4_busy tx_idle got=%b exp=0", tx_idle); end
        wait_release(n);
        checks++; if (n != INHIBIT) begin failures++; $display("FAIL f4_inhibit low_cycles got=%0d exp=%0d", n, INHIBIT); end
        device(1'b1, 0, cap);
        wait_idle();
        cyc(5);
        checks++; if (cap !== 11'b1_0_11110100_0) begin failures++; $display("FAIL f4_frame got=%b exp=%b", cap, 11'b1_0_11110100_0); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL f4_done count got=%0d exp=1", done_cnt - d0); end
        checks++; if (err_cnt - e0 != 0) begin failures++; $display("FAIL f4_err count got=%0d exp=0", err_cnt - e0); end
        checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL f4_idle got=%b exp=1", tx_idle); end
        checks++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin failures++; $display("FAIL f4_lines got=%b%b exp=11", ps2c, ps2d); end
    endtask

    task automatic test_ed();
        int d0, e0, n;
        logic [10:0] cap;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED);
        wait_release(n);
        device(1'b1, 0, cap);
        wait_idle();
        cyc(5);
        checks++; if (cap !== 11'b1_1_11101101_0) begin failures++; $display("FAIL ed_frame got=%b exp=%b", cap, 11'b1_1_11101101_0); end
        checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin failures++; $display("FAIL ed_pulses done=%0d err=%0d exp done=1 err=0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_no_ack();
        int d0, e0, n;
        logic [10:0] cap;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        wait_release(n);
        device(1'b0, 0, cap);
        wait_idle();
        cyc(5);
        checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL noack_err count got=%0d exp=1", err_cnt - e0); end
        checks++; if (done_cnt - d0 != 0) begin failures++; $display("FAIL noack_done count got=%0d exp=0", done_cnt - d0); end
        checks++; if (ps2c !== 1'b1 || ps2d !== 1'b1 || tx_idle !== 1'b1) begin failures++; $display("FAIL noack_state lines=%b%b idle=%b exp 11/1", ps2c, ps2d, tx_idle); end
    endtask

    task automatic test_timeout();
        int d0, e0, n, t;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        wait_release(n);
        t = 0;
        while (tx_err !== 1'b1 && t < 2 * TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        checks++; if (t != TIMEOUT) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", t, TIMEOUT); end
        cyc(5);
        checks++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin failures++; $display("FAIL timeout_pulses err=%0d done=%0d exp err=1 done=0", err_cnt - e0, done_cnt - d0); end
        checks++; if (ps2c !== 1'b1 || ps2d !== 1'b1 || tx_idle !== 1'b1) begin failures++; $display("FAIL timeout_state lines=%b%b idle=%b exp 11/1", ps2c, ps2d, tx_idle); end
    endtask

    task automatic test_glitch_wr();
        int d0, n;
        logic [10:0] cap;
        d0 = done_cnt;
        send(8'hA5);
        wait_release(n);
        fork
            device(1'b1, 4, cap);
            begin
                cyc(12 * HP);
                send(8'h0F);
            end
        join
        wait_idle();
        cyc(5);
        checks++; if (cap !== 11'b1_1_10100101_0) begin failures++; $display("FAIL glitch_frame got=%b exp=%b", cap, 11'b1_1_10100101_0); end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL glitch_done count got=%0d exp=1", done_cnt - d0); end
        cyc(30);
        checks++; if (ps2c !== 1'b1 || tx_idle !== 1'b1) begin failures++; $display("FAIL midwr_ignored ps2c=%b idle=%b exp 1/1", ps2c, tx_idle); end
    endtask

    task automatic test_reset_mid();
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C);
        wait_release(n);
        cyc(2 * HP);
        for (int e = 1; e <= 4; e++) begin
            dev_c_low = 1'b1; cyc(HP);
            dev_c_low = 1'b0; cyc(HP);
        end
        dev_c_low = 1'b1;
        cyc(15);
        reset = 1'b1;
        dev_c_low = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ps2c !== 1'b1 || ps2d !== 1'b1) begin failures++; $display("FAIL midrst_lines got=%b%b exp=11", ps2c, ps2d); end
        checks++; if (tx_idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", tx_idle); end
        cyc(50);
        checks++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin failures++; $display("FAIL midrst_pulses done=%0d err=%0d exp 0/0", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_after_reset();
        int d0, e0, n;
        logic [10:0] cap;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF);
        wait_release(n);
        checks++; if (n != INHIBIT) begin failures++; $display("FAIL post_inhibit low_cycles got=%0d exp=%0d", n, INHIBIT); end
        device(1'b1, 0, cap);
        wait_idle();
        cyc(5);
        checks++; if (cap !== 11'b1_1_11111111_0) begin failures++; $display("FAIL post_frame got=%b exp=%b", cap, 11'b1_1_11111111_0); end
        checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin failures++; $display("FAIL post_pulses done=%0d err=%0d exp 1/0", done_cnt - d0, err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_f4();
        test_ed();
        test_no_ack();
        test_timeout();
        test_glitch_wr();
        test_reset_mid();
        test_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL global_time_limit reached time=%0t", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outbound counterpart of the existing ps2_rx keyboard receiver on the same ps2c/ps2d pair.
- Sends one command byte to the keyboard using the request-to-send sequence, then checks the device ACK. Typical bytes: 8'hED (set LEDs), 8'hF4 (enable), 8'hFF (reset).
- tx_idle gates rx_en of ps2_rx, so the receiver never decodes our own frame.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- INHIBIT_CYCLES, 12_000, cycles ps2c is held low for request-to-send (120 us at 100 MHz; protocol minimum is 100 us).
- TIMEOUT_CYCLES, 1_500_000, watchdog limit in cycles between device clock edges (15 ms).
- FILTER_LEN, 8, length of the ps2c glitch-filter shift register.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- wr_ps2  in  1  one-cycle start strobe; accepted only when tx_idle=1.
- din  in  8  byte to send; captured on the accepted strobe.
- ps2c  inout  1  PS/2 clock, open-drain: drives 0 or z only.
- ps2d  inout  1  PS/2 data, open-drain: drives 0 or z only.
- tx_idle  out  1  high when no transfer is in progress.
- tx_done_tick  out  1  one-cycle pulse on a successful ACK.
- tx_err  out  1  one-cycle pulse on a missing ACK or a timeout.

Behaviour:
- Reset values:
  - FSM = IDLE, tx_idle=1, tx_done_tick=0, tx_err=0.
  - ps2c and ps2d released (z); filter registers all ones.
- Reset asserted mid-transfer: lines are released on the next clk edge and no pulse is issued.
- Glitch filter on ps2c:
  - Filtered level becomes 0 after FILTER_LEN consecutive 0 samples and 1 after FILTER_LEN consecutive 1 samples; otherwise it holds.
  - fall_tick is one cycle wide, on a filtered 1->0 transition.
- Frame register (10 bits) = {1'b1 stop, odd parity, din}, shifted LSB first. Odd parity = ~^din.
- FSM states:
  - IDLE: lines released. On wr_ps2, latch the frame, clear counters, go RTS. wr_ps2 in any other state is ignored.
  - RTS: drive ps2c=0 for INHIBIT_CYCLES. On terminal count, go START.
  - START: drive ps2d=0 (start bit) and release ps2c. On fall_tick, put frame[0] on ps2d, shift, set bit count to 9, go DATA.
  - DATA: on each fall_tick, put the next frame bit on ps2d. "Put 1" means release the line.
    - The 10th fall_tick since START puts the stop bit (line released).
    - The 11th fall_tick moves to ACK.
  - ACK: ps2d released. On fall_tick, sample ps2d:
    - 0: go WAIT_REL.
    - 1: pulse tx_err and go IDLE.
  - WAIT_REL: wait until filtered ps2c=1 and ps2d=1, then pulse tx_done_tick and go IDLE. tx_idle rises in the same cycle as the pulse.
- Watchdog:
  - Counter (21 bits) clears on every fall_tick and on entry to START.
  - If it reaches TIMEOUT_CYCLES in START, DATA, ACK or WAIT_REL: release both lines, pulse tx_err, go IDLE.
- tx_idle=0 in every state except IDLE.
- Data changes only on device falling edges; it is never changed while the filtered ps2c is high.
- Simultaneous timeout and fall_tick in the same cycle: the fall_tick wins and the counter clears.
- Latency from wr_ps2 to ps2c low: 1 cycle.

Decomposition:
- Shared header/package ps2_defs:
  - FSM state encodings (IDLE, RTS, START, DATA, ACK, WAIT_REL).
  - Default INHIBIT_CYCLES and TIMEOUT_CYCLES.
  - Odd-parity function.
- One sub-module, ps2_clk_filter: ps2c synchroniser, glitch filter and falling-edge detector. It is also reusable by ps2_rx.

Test Plan:
- din=8'hF4 (parity 0), device model clocks at 12.5 kHz and ACKs.
  - ps2c is low for exactly 12000 cycles.
  - Bits captured on rising edges are 0,0,0,1,0,1,1,1,1, then parity 0, then stop 1.
  - One tx_done_tick; tx_idle=1 afterwards.
- din=8'hED (parity 1) -> captured data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done_tick.
- Device gives no ACK (ps2d high at the 12th falling edge) -> one tx_err pulse, no tx_done_tick, both lines z.
- Device never clocks after RTS -> tx_err exactly 1_500_000 cycles after entering START; lines released.
- 3-cycle glitch on ps2c during DATA -> no shift. A second wr_ps2 mid-frame -> ignored; the frame still matches the first din.
- reset asserted on the 5th device edge -> next cycle ps2c and ps2d are z, FSM is IDLE, no pulses. A following wr_ps2 completes normally.
